// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg
//   Shared types and helpers for the bit-serial arithmetic blocks.
//   - state_t   : two-state sequencer encoding (IDLE, SHIFT)
//   - cnt_width : bit-counter width able to hold 0..w
package serial_arith_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter must reach w (one past the last bit index), hence w+1.
    function automatic int cnt_width(input int w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/and_gate.sv
// and_gate
//   Two-input AND primitive.
//   Ports: a, b (in), y (out)
module and_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

// File: rtl/full_subtractor_structural.sv
// full_subtractor_structural
//   Gate-level one-bit full subtractor: DIFF = A ^ B ^ BIN,
//   BOUT = (~A & B) | (~(A ^ B) & BIN).
//   Ports: A, B, BIN (in), DIFF, BOUT (out)
module full_subtractor_structural (
    input  logic A,
    input  logic B,
    input  logic BIN,
    output logic DIFF,
    output logic BOUT
);
    logic axb;      // A ^ B
    logic na;       // ~A
    logic xnab;     // ~A ^ B == ~(A ^ B), saves a second inverter
    logic t_gen;    // borrow generated: ~A & B
    logic t_prop;   // borrow propagated: ~(A ^ B) & BIN

    xor_gate u_x_ab   (.a(A),     .b(B),      .y(axb));
    xor_gate u_x_diff (.a(axb),   .b(BIN),    .y(DIFF));
    not_gate u_n_a    (.a(A),                 .y(na));
    and_gate u_a_gen  (.a(na),    .b(B),      .y(t_gen));
    xor_gate u_x_eq   (.a(na),    .b(B),      .y(xnab));
    and_gate u_a_prop (.a(xnab),  .b(BIN),    .y(t_prop));
    or_gate  u_o_bout (.a(t_gen), .b(t_prop), .y(BOUT));
endmodule

// File: rtl/not_gate.sv
// not_gate
//   Inverter primitive.
//   Ports: a (in), y (out)
module not_gate (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

// File: rtl/or_gate.sv
// or_gate
//   Two-input OR primitive.
//   Ports: a, b (in), y (out)
module or_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

// File: rtl/xor_gate.sv
// xor_gate
//   Two-input XOR primitive.
//   Ports: a, b (in), y (out)
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor computing A - B - BIN LSB-first through a
//   single full-subtractor cell over WIDTH cycles.
//   Ports:
//     CLK, RST      clock, async active-high reset
//     START         request; accepted only while BUSY=0
//     A, B, BIN     operands, captured on an accepted START
//     BUSY          operation in progress
//     DONE          one-cycle pulse; DIFF/BOUT valid from this cycle
//     DIFF, BOUT    (A-B-BIN) mod 2^WIDTH and borrow-out, held until next DONE
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DIFF,
    output logic             BOUT
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sa, sb, res, res_next;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             d_bit, b_bit, last;

    full_subtractor_structural u_fs (
        .A   (sa[0]),
        .B   (sb[0]),
        .BIN (brw),
        .DIFF(d_bit),
        .BOUT(b_bit)
    );

    // New difference bit enters at the MSB so the word is aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_res1
            assign res_next = d_bit;
        end else begin : g_resn
            assign res_next = {d_bit, res[WIDTH-1:1]};
        end
    endgenerate

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            DIFF  <= '0;
            BOUT  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        sa    <= A;
                        sb    <= B;
                        brw   <= BIN;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_next;
                    brw <= b_bit;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        DIFF  <= res_next;
                        BOUT  <= b_bit;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Three instances (WIDTH 8, 4, 1). Drivers push expected results into
//   per-instance queues; monitors pop and compare whenever DONE is seen.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start4, bin4, busy4, done4, bout4;
    logic [3:0] a4, b4, diff4;
    logic       start1, bin1, busy1, done1, bout1;
    logic [0:0] a1, b1, diff1;

    serial_subtractor #(.WIDTH(8)) u_w8 (
        .CLK(clk), .RST(rst), .START(start8), .A(a8), .B(b8), .BIN(bin8),
        .BUSY(busy8), .DONE(done8), .DIFF(diff8), .BOUT(bout8));
    serial_subtractor #(.WIDTH(4)) u_w4 (
        .CLK(clk), .RST(rst), .START(start4), .A(a4), .B(b4), .BIN(bin4),
        .BUSY(busy4), .DONE(done4), .DIFF(diff4), .BOUT(bout4));
    serial_subtractor #(.WIDTH(1)) u_w1 (
        .CLK(clk), .RST(rst), .START(start1), .A(a1), .B(b1), .BIN(bin1),
        .BUSY(busy1), .DONE(done1), .DIFF(diff1), .BOUT(bout1));

    int total = 0;
    int bad   = 0;
    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [1:0] q1[$];
    logic [8:0] last8;   // model's view of the currently held {BOUT, DIFF}

    // Reference: plain signed arithmetic; borrow-out is a negative result.
    function automatic logic [8:0] model(input int w, input int a, input int b, input int bin);
        int r;
        r = a - b - bin;
        return {1'b0, 8'(r & ((1 << w) - 1))} | ((r < 0) ? (9'd1 << w) : 9'd0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        logic [8:0] e8; logic [4:0] e4; logic [1:0] e1;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) chk("w8 unexpected done", 1, 0);
            else begin
                e8 = q8.pop_front();
                chk("w8 diff", diff8, e8[7:0]);
                chk("w8 bout", bout8, e8[8]);
            end
        end
        if (done4 === 1'b1) begin
            if (q4.size() == 0) chk("w4 unexpected done", 1, 0);
            else begin
                e4 = q4.pop_front();
                chk("w4 diff", diff4, e4[3:0]);
                chk("w4 bout", bout4, e4[4]);
            end
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) chk("w1 unexpected done", 1, 0);
            else begin
                e1 = q1.pop_front();
                chk("w1 diff", diff1, e1[0]);
                chk("w1 bout", bout1, e1[1]);
            end
        end
    end

    // WIDTH=8 operation with timing and output-hold checks.
    // ign: cycle index at which a (to be ignored) START pulse is driven.
    // chain: START is driven in the current (DONE) cycle instead of the next negedge.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input int ign, input bit chain);
        logic [8:0] e;
        if (!chain) @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        e = model(8, a, b, bin);
        q8.push_back(e);
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i < 8) begin
                chk("w8 busy", busy8, 1);
                chk("w8 done early", done8, 0);
                chk("w8 hold diff", diff8, last8[7:0]);
                chk("w8 hold bout", bout8, last8[8]);
            end else begin
                chk("w8 done at W", done8, 1);
                chk("w8 busy at done", busy8, 0);
                last8 = e;
            end
            if (i == ign && i > 0) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
            end else begin
                start8 = 1'b0;
                a8 = $urandom_range(255); b8 = $urandom_range(255);  // free to change
            end
        end
    endtask

    task automatic opn(input int w, input int a, input int b, input int bin);
        @(negedge clk);
        if (w == 4) begin
            a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bin); start4 = 1'b1;
            q4.push_back(5'(model(4, a, b, bin)));
        end else begin
            a1 = 1'(a); b1 = 1'(b); bin1 = 1'(bin); start1 = 1'b1;
            q1.push_back(2'(model(1, a, b, bin)));
        end
        for (int i = 0; i <= w; i++) begin
            @(posedge clk); #1;
            start4 = 1'b0; start1 = 1'b0;
            if (w == 4) chk((i < w) ? "w4 done early" : "w4 done at W", done4, (i == w) ? 1 : 0);
            else        chk((i < w) ? "w1 done early" : "w1 done at W", done1, (i == w) ? 1 : 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        last8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy8", busy8, 0); chk("rst done8", done8, 0);
        chk("rst diff8", diff8, 0); chk("rst bout8", bout8, 0);
        chk("rst busy4", busy4, 0); chk("rst diff4", diff4, 0);
        chk("rst busy1", busy1, 0); chk("rst done1", done1, 0);
        @(negedge clk); rst = 1'b0;

        // Directed cases
        op8(8'h5A, 8'h3C, 1'b0, 0, 0);
        op8(8'h00, 8'h01, 1'b0, 0, 0);
        op8(8'h80, 8'h7F, 1'b1, 0, 0);
        op8(8'h33, 8'h11, 1'b0, 3, 0);      // extra START mid-operation ignored
        op8(8'h44, 8'h22, 1'b0, 0, 0);
        op8(8'h10, 8'h20, 1'b0, 0, 1);      // accepted in the DONE cycle

        // Reset after the 4th SHIFT edge
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h11; bin8 = 0; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst busy8", busy8, 0); chk("midrst diff8", diff8, 0);
        chk("midrst bout8", bout8, 0); chk("midrst done8", done8, 0);
        @(negedge clk); rst = 1'b0; last8 = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("postrst no done", done8, 0);
        end
        op8(8'h09, 8'h04, 1'b0, 0, 0);

        // Randomized ops (hold checks compare against each previous result)
        for (int n = 0; n < 40; n++)
            op8(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)), 0, 0);

        // Exhaustive narrow widths
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    opn(4, a, b, c);
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < 2; c++)
                    opn(1, a, b, c);

        repeat (3) @(posedge clk);
        #1;
        chk("w8 queue drained", q8.size(), 0);
        chk("w4 queue drained", q4.size(), 0);
        chk("w1 queue drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
